rv_dm_responder: RTL and testbench
==================================

Name: rv_dm_responder

Overview:
- Target-side end of the uRV data-memory interface. The execute stage issues load/store strobes with address, byte selects and store data; this block accepts them and returns ready, load data and a completion pulse.
- Contains a word-organised local RAM with a programmable number of wait states and out-of-range detection.
- Sits between the core's dm_* port and on-chip data RAM. It is also the bench model for exercising core stall behaviour.

Parameters:
- g_size_words, 1024, RAM depth in 32-bit words (power of 2, minimum 4).
- g_wait_states, 0, extra cycles between request accept and completion (0..15).
- g_base_addr, 32'h0, byte address of word 0; must be aligned to g_size_words*4.

Ports:
- clk_i  in  1  system clock
- rst_n_i  in  1  asynchronous active-low reset
- dm_addr_i  in  32  byte address from the execute stage
- dm_data_s_i  in  32  store data, already lane-replicated by the initiator
- dm_data_select_i  in  4  byte-lane enables (bit n = bits 8n+7:8n)
- dm_store_i  in  1  store strobe
- dm_load_i  in  1  load strobe
- dm_ready_o  out  1  responder can accept a request this cycle
- dm_data_l_o  out  32  load data (full word; lane extraction is done in writeback)
- dm_load_done_o  out  1  one-cycle pulse, dm_data_l_o valid
- dm_store_done_o  out  1  one-cycle pulse, store committed
- dm_error_o  out  1  one-cycle pulse with a done pulse, access was out of range

Behaviour:
- One clock; reset is asynchronous and active-low on rst_n_i. All flops except the RAM array reset.
- Reset values:
  - dm_ready_o = 1.
  - dm_data_l_o = 0.
  - All done and error pulses = 0.
  - FSM = IDLE.
  - RAM contents are undefined and are never cleared.
- Acceptance: a request is accepted on a rising edge where (dm_load_i | dm_store_i) & dm_ready_o.
  - On acceptance the block registers the address, data, select and type.
  - Strobes while dm_ready_o = 0 are ignored; the initiator re-issues them.
- Simultaneous dm_load_i and dm_store_i is illegal. The responder treats it as a store, and the bench asserts it never occurs.
- Range check: in_range = (dm_addr_i - g_base_addr) < g_size_words*4, unsigned 32-bit. Word index = offset[log2(g_size_words)+1:2]. Address bits [1:0] are ignored for indexing.
- FSM states:
  - IDLE: dm_ready_o = 1. On accept, go to WAIT if g_wait_states > 0, else ACCESS.
  - WAIT: dm_ready_o = 0. A 4-bit counter loads g_wait_states-1 on accept and decrements each cycle. At 0, go to ACCESS.
  - ACCESS: dm_ready_o = 0.
    - Store: write enabled lanes if in range.
    - Load: RAM read.
    - Go to DONE.
  - DONE: pulse dm_load_done_o or dm_store_done_o for the latched type, and pulse dm_error_o if out of range.
    - On a load, dm_data_l_o = RAM word, or 32'h0 if out of range. dm_data_l_o holds until the next load completes.
    - dm_ready_o = 1 in DONE, so back-to-back accept is allowed. Accepting in DONE goes to WAIT/ACCESS; otherwise go to IDLE.
- Latency with g_wait_states = N: the done pulse arrives N+2 cycles after the accept edge. Throughput is one access per N+2 cycles.
- Out-of-range store: no RAM write; dm_store_done_o and dm_error_o both pulse.
- dm_data_select_i = 0 on a store: completes normally with no bytes changed.
- Store followed by a load to the same word: the load returns the updated data, because accesses are serialised.
- Reset asserted mid-operation: the FSM returns to IDLE immediately and the pending access is abandoned.
  - A store abandoned before ACCESS is not written.
  - No done pulse is emitted for the abandoned access.

Decomposition:
- Shared package (rv_defs):
  - FSM state encodings DMR_IDLE/WAIT/ACCESS/DONE.
  - Request type constants DMR_LOAD/DMR_STORE.
  - Width constant for the wait counter.
- One sub-module, rv_dm_ram:
  - single-port, byte-write-enable synchronous RAM, g_size_words x 32;
  - ports clk_i, addr, wdata, we[3:0], re, rdata;
  - 1-cycle read latency, no reset.
- FSM, range check and output registers live in rv_dm_responder.

Test Plan:
- g_wait_states=0: store 32'hDEADBEEF to 0x10 with select 4'hF, then load 0x10 → dm_store_done_o at accept+2; dm_load_done_o at accept+2 with data 32'hDEADBEEF; dm_error_o never asserted.
- Byte store: word 0x20 preset to 32'h11223344; store 32'hAAAAAAAA, select 4'b0100 → subsequent load returns 32'h11AA3344.
- g_wait_states=3: load from 0x4 → dm_ready_o low for exactly 4 cycles after accept (WAIT×3 plus ACCESS), and the done pulse arrives at accept+5. A strobe issued during the low window produces no extra done pulse.
- Out of range with g_size_words=1024, base 0: load 0x1000 → dm_load_done_o and dm_error_o pulse together with data 32'h0. Store to 0x1000 → word 0x0 is unchanged.
- Back-to-back: load accepted in the DONE cycle of a previous store to the same address → the load returns the new value and the two done pulses are N+2 cycles apart.
- Reset mid-WAIT (g_wait_states=5): store to 0x8 after preset 32'h0; drop rst_n_i 2 cycles after accept → no done pulse, dm_ready_o=1 asynchronously, later load of 0x8 returns 32'h0.

Source files
------------

// File: rtl/rv_defs.sv
// rtl/rv_defs.sv - shared types and constants for the uRV data-memory responder
package rv_defs;

    typedef enum logic [1:0] {
        DMR_IDLE   = 2'd0,
        DMR_WAIT   = 2'd1,
        DMR_ACCESS = 2'd2,
        DMR_DONE   = 2'd3
    } dmr_state_e;

    typedef enum logic {
        DMR_LOAD  = 1'b0,
        DMR_STORE = 1'b1
    } dmr_req_e;

    localparam int DMR_WCNT_W = 4;

endpackage

// File: rtl/rv_dm_ram.sv
// rtl/rv_dm_ram.sv - single-port byte-write-enable synchronous RAM, 1-cycle read
module rv_dm_ram #(
    parameter int g_size_words = 1024,
    parameter int AW           = $clog2(g_size_words)
) (
    input  logic          clk_i,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    input  logic [3:0]    we,
    input  logic          re,
    output logic [31:0]   rdata
);

    logic [31:0] mem [g_size_words];

    always_ff @(posedge clk_i) begin
        for (int b = 0; b < 4; b++) begin
            if (we[b]) begin
                mem[addr][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
        if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/rv_dm_responder.sv
// rtl/rv_dm_responder.sv - target side of the uRV dm_* port: local RAM with wait states
module rv_dm_responder
    import rv_defs::*;
#(
    parameter int          g_size_words  = 1024,
    parameter int          g_wait_states = 0,
    parameter logic [31:0] g_base_addr   = 32'h0
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic [31:0] dm_addr_i,
    input  logic [31:0] dm_data_s_i,
    input  logic [3:0]  dm_data_select_i,
    input  logic        dm_store_i,
    input  logic        dm_load_i,
    output logic        dm_ready_o,
    output logic [31:0] dm_data_l_o,
    output logic        dm_load_done_o,
    output logic        dm_store_done_o,
    output logic        dm_error_o
);

    localparam int                    AW          = $clog2(g_size_words);
    localparam logic [31:0]           RANGE_BYTES = 32'(g_size_words * 4);
    localparam logic [DMR_WCNT_W-1:0] WAIT_INIT   = DMR_WCNT_W'(g_wait_states - 1);
    localparam dmr_state_e            START_ST    = (g_wait_states > 0) ? DMR_WAIT : DMR_ACCESS;

    dmr_state_e            state_q, state_d;
    logic [DMR_WCNT_W-1:0] cnt_q, cnt_d;
    logic [AW-1:0]         idx_q;
    logic [31:0]           wdata_q;
    logic [3:0]            sel_q;
    dmr_req_e              type_q;
    logic                  range_q;
    logic [31:0]           data_l_q;

    logic [31:0] offset;
    logic        in_range;
    logic        accept;
    logic [3:0]  ram_we;
    logic        ram_re;
    logic [31:0] ram_rdata;
    logic [31:0] load_word;
    logic        done_load;

    assign offset     = dm_addr_i - g_base_addr;
    assign in_range   = offset < RANGE_BYTES;
    assign dm_ready_o = (state_q == DMR_IDLE) || (state_q == DMR_DONE);
    assign accept     = (dm_load_i | dm_store_i) & dm_ready_o;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ram_we  = 4'h0;
        ram_re  = 1'b0;
        case (state_q)
            DMR_IDLE: begin
                if (accept) begin
                    state_d = START_ST;
                    cnt_d   = WAIT_INIT;
                end
            end
            DMR_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = DMR_ACCESS;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DMR_ACCESS: begin
                ram_we  = (type_q == DMR_STORE && range_q) ? sel_q : 4'h0;
                ram_re  = (type_q == DMR_LOAD);
                state_d = DMR_DONE;
            end
            DMR_DONE: begin
                // Ready is high here, so a new request can chain straight in.
                state_d = DMR_IDLE;
                if (accept) begin
                    state_d = START_ST;
                    cnt_d   = WAIT_INIT;
                end
            end
            default: state_d = DMR_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q  <= DMR_IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            wdata_q  <= '0;
            sel_q    <= '0;
            type_q   <= DMR_LOAD;
            range_q  <= 1'b0;
            data_l_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                idx_q   <= offset[AW+1:2];
                wdata_q <= dm_data_s_i;
                sel_q   <= dm_data_select_i;
                type_q  <= dm_store_i ? DMR_STORE : DMR_LOAD;
                range_q <= in_range;
            end
            if (done_load) begin
                data_l_q <= load_word;
            end
        end
    end

    rv_dm_ram #(
        .g_size_words(g_size_words),
        .AW          (AW)
    ) u_ram (
        .clk_i(clk_i),
        .addr (idx_q),
        .wdata(wdata_q),
        .we   (ram_we),
        .re   (ram_re),
        .rdata(ram_rdata)
    );

    // Load data is shown straight from the RAM in DONE and held in data_l_q afterwards.
    assign done_load       = (state_q == DMR_DONE) && (type_q == DMR_LOAD);
    assign load_word       = range_q ? ram_rdata : 32'h0;
    assign dm_data_l_o     = done_load ? load_word : data_l_q;
    assign dm_load_done_o  = done_load;
    assign dm_store_done_o = (state_q == DMR_DONE) && (type_q == DMR_STORE);
    assign dm_error_o      = (state_q == DMR_DONE) && !range_q;

endmodule

// File: tb/tb_rv_dm_responder.sv
// tb/tb_rv_dm_responder.sv - directed bench over three wait-state configurations (0, 3, 5)
module tb_rv_dm_responder;

    logic        clk = 1'b0;
    logic        rst_n [3];
    logic [31:0] addr  [3];
    logic [31:0] sdat  [3];
    logic [3:0]  sel   [3];
    logic        st    [3];
    logic        ld    [3];
    logic        ready [3];
    logic [31:0] ldat  [3];
    logic        ldone [3];
    logic        sdone [3];
    logic        err   [3];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        rv_dm_responder #(
            .g_size_words (1024),
            .g_wait_states((g == 0) ? 0 : ((g == 1) ? 3 : 5)),
            .g_base_addr  (32'h0)
        ) u_dut (
            .clk_i           (clk),
            .rst_n_i         (rst_n[g]),
            .dm_addr_i       (addr[g]),
            .dm_data_s_i     (sdat[g]),
            .dm_data_select_i(sel[g]),
            .dm_store_i      (st[g]),
            .dm_load_i       (ld[g]),
            .dm_ready_o      (ready[g]),
            .dm_data_l_o     (ldat[g]),
            .dm_load_done_o  (ldone[g]),
            .dm_store_done_o (sdone[g]),
            .dm_error_o      (err[g])
        );
    end

    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            assert (!(ld[k] && st[k]));
        end
    end

    // Issues one request (now=1: in the current negedge slot) and waits for its done pulse.
    task automatic do_access(input int k, input bit is_st, input logic [31:0] a,
                             input logic [31:0] d, input logic [3:0] s, input bit now,
                             output logic [31:0] rd, output int lat, output bit e);
        bit got;
        if (!now) @(negedge clk);
        checks++;
        if (ready[k] !== 1'b1) begin
            errors++;
            $display("FAIL ready_before_req[%0d]: got %b expected 1", k, ready[k]);
        end
        addr[k] = a; sdat[k] = d; sel[k] = s;
        st[k] = is_st; ld[k] = !is_st;
        @(negedge clk);
        st[k] = 1'b0; ld[k] = 1'b0;
        lat = 1; got = 1'b0; rd = 32'h0; e = 1'b0;
        while (!got && lat < 40) begin
            if (is_st ? sdone[k] : ldone[k]) begin
                got = 1'b1;
                rd  = ldat[k];
                e   = err[k];
                checks++;
                if ((is_st ? ldone[k] : sdone[k]) !== 1'b0) begin
                    errors++;
                    $display("FAIL wrong_done_type[%0d]: got 1 expected 0", k);
                end
            end else begin
                @(negedge clk);
                lat++;
            end
        end
        if (!got) begin
            errors++;
            $display("FAIL done_timeout[%0d]: got none expected a done pulse", k);
        end
    endtask

    task automatic test_reset();
        for (int k = 0; k < 3; k++) begin
            rst_n[k] = 1'b0; st[k] = 1'b0; ld[k] = 1'b0;
            addr[k] = 32'h0; sdat[k] = 32'h0; sel[k] = 4'h0;
        end
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if ({ready[k], ldone[k], sdone[k], err[k]} !== 4'b1000) begin
                errors++;
                $display("FAIL reset_flags[%0d]: got %b expected 1000", k,
                         {ready[k], ldone[k], sdone[k], err[k]});
            end
            checks++;
            if (ldat[k] !== 32'h0) begin
                errors++;
                $display("FAIL reset_data[%0d]: got %h expected 00000000", k, ldat[k]);
            end
        end
        for (int k = 0; k < 3; k++) rst_n[k] = 1'b1;
    endtask

    task automatic test_basic();
        logic [31:0] rd; int lat; bit e;
        do_access(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b0, rd, lat, e);
        checks++;
        if (lat != 2 || e !== 1'b0) begin
            errors++;
            $display("FAIL basic_store: got lat %0d err %b expected lat 2 err 0", lat, e);
        end
        do_access(0, 1'b0, 32'h10, 32'h0, 4'hF, 1'b0, rd, lat, e);
        checks++;
        if (lat != 2 || e !== 1'b0 || rd !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL basic_load: got lat %0d err %b data %h expected lat 2 err 0 data deadbeef",
                     lat, e, rd);
        end
        @(negedge clk);
        checks++;
        if (ldat[0] !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL load_data_hold: got %h expected deadbeef", ldat[0]);
        end
    endtask

    task automatic test_byte_lanes();
        logic [31:0] rd; int lat; bit e;
        do_access(0, 1'b1, 32'h20, 32'h11223344, 4'hF, 1'b0, rd, lat, e);
        do_access(0, 1'b1, 32'h20, 32'hAAAAAAAA, 4'b0100, 1'b0, rd, lat, e);
        do_access(0, 1'b0, 32'h20, 32'h0, 4'hF, 1'b0, rd, lat, e);
        checks++;
        if (rd !== 32'h11AA3344) begin
            errors++;
            $display("FAIL byte_store: got %h expected 11aa3344", rd);
        end
        do_access(0, 1'b1, 32'h20, 32'h55555555, 4'h0, 1'b0, rd, lat, e);
        checks++;
        if (lat != 2 || e !== 1'b0) begin
            errors++;
            $display("FAIL zero_select_done: got lat %0d err %b expected lat 2 err 0", lat, e);
        end
        do_access(0, 1'b0, 32'h23, 32'h0, 4'hF, 1'b0, rd, lat, e);
        checks++;
        if (rd !== 32'h11AA3344) begin
            errors++;
            $display("FAIL zero_select_data: got %h expected 11aa3344", rd);
        end
    endtask

    task automatic test_out_of_range();
        logic [31:0] rd; int lat; bit e;
        do_access(0, 1'b1, 32'h0, 32'h12345678, 4'hF, 1'b0, rd, lat, e);
        do_access(0, 1'b1, 32'hFFC, 32'h0F0E0D0C, 4'hF, 1'b0, rd, lat, e);
        do_access(0, 1'b0, 32'h1000, 32'h0, 4'hF, 1'b0, rd, lat, e);
        checks++;
        if (lat != 2 || e !== 1'b1 || rd !== 32'h0) begin
            errors++;
            $display("FAIL oor_load: got lat %0d err %b data %h expected lat 2 err 1 data 00000000",
                     lat, e, rd);
        end
        do_access(0, 1'b1, 32'h1000, 32'hFFFFFFFF, 4'hF, 1'b0, rd, lat, e);
        checks++;
        if (lat != 2 || e !== 1'b1) begin
            errors++;
            $display("FAIL oor_store: got lat %0d err %b expected lat 2 err 1", lat, e);
        end
        do_access(0, 1'b0, 32'h0, 32'h0, 4'hF, 1'b0, rd, lat, e);
        checks++;
        if (rd !== 32'h12345678 || e !== 1'b0) begin
            errors++;
            $display("FAIL oor_no_write: got %h err %b expected 12345678 err 0", rd, e);
        end
        do_access(0, 1'b0, 32'hFFE, 32'h0, 4'hF, 1'b0, rd, lat, e);
        checks++;
        if (rd !== 32'h0F0E0D0C || e !== 1'b0) begin
            errors++;
            $display("FAIL top_word: got %h err %b expected 0f0e0d0c err 0", rd, e);
        end
    endtask

    task automatic test_wait_states();
        logic [31:0] rd; int lat; bit e;
        int low; int dones; int first; logic [31:0] got_data;
        do_access(1, 1'b1, 32'h4, 32'h0BADF00D, 4'hF, 1'b0, rd, lat, e);
        checks++;
        if (lat != 5) begin
            errors++;
            $display("FAIL wait_store_latency: got %0d expected 5", lat);
        end
        @(negedge clk);
        addr[1] = 32'h4; ld[1] = 1'b1;
        low = 0; dones = 0; first = 0; got_data = 32'h0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (!ready[1]) low++;
            if (ldone[1]) begin
                dones++;
                if (first == 0) begin
                    first = c;
                    got_data = ldat[1];
                end
            end
            if (c == 4) ld[1] = 1'b0;
        end
        checks++;
        if (low != 4) begin
            errors++;
            $display("FAIL wait_ready_low: got %0d cycles expected 4", low);
        end
        checks++;
        if (first != 5 || got_data !== 32'h0BADF00D) begin
            errors++;
            $display("FAIL wait_load: got cycle %0d data %h expected cycle 5 data 0badf00d",
                     first, got_data);
        end
        checks++;
        if (dones != 1) begin
            errors++;
            $display("FAIL wait_ignored_strobe: got %0d done pulses expected 1", dones);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd; int lat; bit e;
        do_access(1, 1'b1, 32'h40, 32'hCAFEF00D, 4'hF, 1'b0, rd, lat, e);
        do_access(1, 1'b0, 32'h40, 32'h0, 4'hF, 1'b1, rd, lat, e);
        checks++;
        if (lat != 5 || rd !== 32'hCAFEF00D) begin
            errors++;
            $display("FAIL b2b_wait3: got gap %0d data %h expected gap 5 data cafef00d", lat, rd);
        end
        do_access(0, 1'b1, 32'h44, 32'h600DCAFE, 4'hF, 1'b0, rd, lat, e);
        do_access(0, 1'b0, 32'h44, 32'h0, 4'hF, 1'b1, rd, lat, e);
        checks++;
        if (lat != 2 || rd !== 32'h600DCAFE) begin
            errors++;
            $display("FAIL b2b_wait0: got gap %0d data %h expected gap 2 data 600dcafe", lat, rd);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd; int lat; bit e; int dones;
        do_access(2, 1'b1, 32'h8, 32'h0, 4'hF, 1'b0, rd, lat, e);
        checks++;
        if (lat != 7) begin
            errors++;
            $display("FAIL wait5_latency: got %0d expected 7", lat);
        end
        @(negedge clk);
        addr[2] = 32'h8; sdat[2] = 32'hFFFFFFFF; sel[2] = 4'hF; st[2] = 1'b1;
        @(negedge clk);
        st[2] = 1'b0;
        @(negedge clk);
        checks++;
        if (ready[2] !== 1'b0) begin
            errors++;
            $display("FAIL mid_wait_ready: got %b expected 0", ready[2]);
        end
        rst_n[2] = 1'b0;
        #1;
        checks++;
        if (ready[2] !== 1'b1) begin
            errors++;
            $display("FAIL async_reset_ready: got %b expected 1", ready[2]);
        end
        dones = 0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (sdone[2] || ldone[2] || err[2]) dones++;
            if (c == 2) rst_n[2] = 1'b1;
        end
        checks++;
        if (dones != 0) begin
            errors++;
            $display("FAIL abandoned_done: got %0d pulses expected 0", dones);
        end
        do_access(2, 1'b0, 32'h8, 32'h0, 4'hF, 1'b0, rd, lat, e);
        checks++;
        if (rd !== 32'h0 || lat != 7) begin
            errors++;
            $display("FAIL abandoned_store: got %h lat %0d expected 00000000 lat 7", rd, lat);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_byte_lanes();
        test_out_of_range();
        test_wait_states();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
